// File: rtl/isp_blc_auto.sv
// isp_blc_auto -- black-level correction with optical-black auto estimation.
//
// The black level is subtracted per Bayer channel with a floor at 0. The
// four channel levels are latched at each in_vsync rising edge. In auto
// mode they come from the estimates built from the optical-black (OB)
// window of the previous frame; in manual mode they come from black_*.
//
// Ports
//   pclk, rst          clock; synchronous active-high reset
//   black_r/gr/gb/b    manual black levels
//   auto_en            1: use estimated levels at the next frame start
//   bypass             1: pass the pixel unmodified (sampled with the pixel)
//   in_href/vsync/raw  input video (vsync high during vertical blanking)
//   out_href/vsync/raw output video, two cycles behind the input
//   est_r/gr/gb/b      latest OB estimates
//   est_valid          one-cycle pulse when the estimates update

// One Bayer channel: OB accumulator, rounded estimate and active level.
module isp_blc_chan #(
  parameter int BITS = 12,
  parameter int LOGN = 5
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            clr,
  input  logic            add,
  input  logic            upd,
  input  logic            load,
  input  logic            auto_en,
  input  logic [BITS-1:0] pix,
  input  logic [BITS-1:0] black,
  output logic [BITS-1:0] est,
  output logic [BITS-1:0] lvl
);
  localparam int ACC_W = BITS + LOGN;
  // Half of N for round-to-nearest; zero when N == 1.
  localparam logic [ACC_W-1:0] HALF = ACC_W'((1 << LOGN) >> 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] rnd;

  // The accumulator holds at most N full-scale pixels, so adding N/2
  // still fits ACC_W and the shifted result fits BITS.
  assign rnd = acc + HALF;

  always_ff @(posedge pclk) begin
    if (rst) begin
      acc <= '0;
      est <= '0;
      lvl <= '0;
    end else begin
      if (clr)      acc <= '0;
      else if (add) acc <= acc + ACC_W'(pix);
      if (upd)  est <= BITS'(rnd >> LOGN);
      if (load) lvl <= auto_en ? est : black;
    end
  end
endmodule

module isp_blc_auto #(
  parameter int BITS     = 12,
  parameter int WIDTH    = 1280,
  parameter int HEIGHT   = 960,
  parameter int BAYER    = 0,
  parameter int OB_LINES = 4,
  parameter int OB_COLS  = 64
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic [BITS-1:0] black_r,
  input  logic [BITS-1:0] black_gr,
  input  logic [BITS-1:0] black_gb,
  input  logic [BITS-1:0] black_b,
  input  logic            auto_en,
  input  logic            bypass,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_raw,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_raw,
  output logic [BITS-1:0] est_r,
  output logic [BITS-1:0] est_gr,
  output logic [BITS-1:0] est_gb,
  output logic [BITS-1:0] est_b,
  output logic            est_valid
);
  // OB window can never exceed the active frame.
  localparam int OBL    = (OB_LINES < HEIGHT) ? OB_LINES : HEIGHT;
  localparam int OBC    = (OB_COLS < WIDTH) ? OB_COLS : WIDTH;
  localparam int LOGN   = $clog2(OBL * OBC / 4);
  localparam int LW     = $clog2(OBL + 1);
  localparam int CW     = $clog2(OBC + 1);
  localparam int STAGES = 2;

  logic          href_d, vsync_d, armed;
  logic          pix_par, line_par;
  logic [LW-1:0] line_cnt;
  logic [CW-1:0] col_cnt;
  logic [1:0]    ch;
  logic          href_fall, vs_rise, ob, est_upd;

  assign href_fall = href_d & ~in_href;
  assign vs_rise   = in_vsync & ~vsync_d;
  assign ch        = 2'(BAYER) ^ {line_par, pix_par};
  // armed stays low after reset until a frame start, so a frame cut by
  // reset never contributes to the estimates.
  assign ob        = armed & ~in_vsync & in_href &
                     (line_cnt < LW'(OBL)) & (col_cnt < CW'(OBC));
  assign est_upd   = armed & ~in_vsync & href_fall &
                     (line_cnt == LW'(OBL - 1));

  // Frame position tracking. Counters saturate at the OB window edge,
  // which is all the classification needs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      href_d    <= 1'b0;
      vsync_d   <= 1'b0;
      armed     <= 1'b0;
      pix_par   <= 1'b0;
      line_par  <= 1'b0;
      line_cnt  <= '0;
      col_cnt   <= '0;
      est_valid <= 1'b0;
    end else begin
      href_d    <= in_href;
      vsync_d   <= in_vsync;
      est_valid <= est_upd;
      if (vs_rise) armed <= 1'b1;
      if (!in_href) begin
        pix_par <= 1'b0;
        col_cnt <= '0;
      end else begin
        pix_par <= ~pix_par;
        if (col_cnt < CW'(OBC)) col_cnt <= col_cnt + 1'b1;
      end
      if (in_vsync) begin
        line_par <= 1'b0;
        line_cnt <= '0;
      end else if (href_fall) begin
        line_par <= ~line_par;
        if (line_cnt < LW'(OBL)) line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  logic [3:0][BITS-1:0] black, est, lvl;
  assign black = {black_b, black_gb, black_gr, black_r};

  for (genvar i = 0; i < 4; i++) begin : g_ch
    isp_blc_chan #(.BITS(BITS), .LOGN(LOGN)) u_ch (
      .pclk    (pclk),
      .rst     (rst),
      .clr     (vs_rise),
      .add     (ob && (ch == 2'(i))),
      .upd     (est_upd),
      .load    (vs_rise),
      .auto_en (auto_en),
      .pix     (in_raw),
      .black   (black[i]),
      .est     (est[i]),
      .lvl     (lvl[i])
    );
  end

  assign est_r  = est[0];
  assign est_gr = est[1];
  assign est_gb = est[2];
  assign est_b  = est[3];

  // Two-stage datapath: stage 1 resolves the channel level, stage 2
  // does the floored subtraction.
  logic [STAGES-1:0] href_pipe, vs_pipe;
  logic [BITS-1:0]   p1_raw, p1_lvl;
  logic              p1_byp;

  always_ff @(posedge pclk) begin
    if (rst) begin
      href_pipe <= '0;
      vs_pipe   <= '0;
      p1_raw    <= '0;
      p1_lvl    <= '0;
      p1_byp    <= 1'b0;
      out_raw   <= '0;
    end else begin
      href_pipe <= {href_pipe[STAGES-2:0], in_href};
      vs_pipe   <= {vs_pipe[STAGES-2:0], in_vsync};
      p1_raw    <= in_raw;
      p1_lvl    <= lvl[ch];
      p1_byp    <= bypass;
      if (p1_byp)               out_raw <= p1_raw;
      else if (p1_raw > p1_lvl) out_raw <= p1_raw - p1_lvl;
      else                      out_raw <= '0;
    end
  end

  assign out_href  = href_pipe[STAGES-1];
  assign out_vsync = vs_pipe[STAGES-1];
endmodule

// File: tb/tb_isp_blc_auto.sv
// Directed bench for isp_blc_auto (BITS=12, OB_LINES=2, OB_COLS=4, RGGB).
module tb_isp_blc_auto;
  localparam int BITS = 12;
  typedef logic [BITS-1:0] pv_t [6];

  logic            pclk = 1'b0;
  logic            rst;
  logic [BITS-1:0] black_r, black_gr, black_gb, black_b;
  logic            auto_en, bypass;
  logic            in_href, in_vsync;
  logic [BITS-1:0] in_raw;
  logic            out_href, out_vsync;
  logic [BITS-1:0] out_raw;
  logic [BITS-1:0] est_r, est_gr, est_gb, est_b;
  logic            est_valid;

  isp_blc_auto #(
    .BITS(12), .WIDTH(8), .HEIGHT(4), .BAYER(0), .OB_LINES(2), .OB_COLS(4)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .black_r   (black_r),
    .black_gr  (black_gr),
    .black_gb  (black_gb),
    .black_b   (black_b),
    .auto_en   (auto_en),
    .bypass    (bypass),
    .in_href   (in_href),
    .in_vsync  (in_vsync),
    .in_raw    (in_raw),
    .out_href  (out_href),
    .out_vsync (out_vsync),
    .out_raw   (out_raw),
    .est_r     (est_r),
    .est_gr    (est_gr),
    .est_gb    (est_gb),
    .est_b     (est_b),
    .est_valid (est_valid)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Expected output for the pixel driven one step earlier.
  logic [BITS-1:0] q_raw;
  logic            q_href, q_vs;

  always @(negedge pclk) if (est_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_est(input string tag, input int r, input int gr, input int gb, input int b);
    chk({tag, "_est_r"},  64'(est_r),  64'(r));
    chk({tag, "_est_gr"}, 64'(est_gr), 64'(gr));
    chk({tag, "_est_gb"}, 64'(est_gb), 64'(gb));
    chk({tag, "_est_b"},  64'(est_b),  64'(b));
  endtask

  // One pclk step; checks the outputs for the pixel of the previous step.
  task automatic drive(input logic h, input logic v, input logic [BITS-1:0] raw,
                       input logic [BITS-1:0] eraw);
    in_href = h; in_vsync = v; in_raw = raw;
    @(posedge pclk); #1;
    chk("out_raw",   64'(out_raw),   64'(q_raw));
    chk("out_href",  64'(out_href),  64'(q_href));
    chk("out_vsync", 64'(out_vsync), 64'(q_vs));
    q_raw = eraw; q_href = h; q_vs = v;
  endtask

  task automatic line(input int n, input pv_t px, input pv_t ex);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, px[i], ex[i]);
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic vs();
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
  endtask

  // Reset with arbitrary inputs; everything must read zero while held.
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_href = 1'($urandom); in_vsync = 1'($urandom); in_raw = BITS'($urandom);
      @(posedge pclk); #1;
      chk("rst_out_raw",   64'(out_raw),   0);
      chk("rst_out_href",  64'(out_href),  0);
      chk("rst_out_vsync", 64'(out_vsync), 0);
      chk("rst_est_valid", 64'(est_valid), 0);
      chk_est("rst", 0, 0, 0, 0);
    end
    rst = 1'b0;
    q_raw = '0; q_href = 1'b0; q_vs = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_href = 1'b0; in_vsync = 1'b0; in_raw = '0;
    bypass = 1'b0; auto_en = 1'b0;
    black_r = 12'd64; black_gr = '0; black_gb = '0; black_b = '0;
    q_raw = '0; q_href = 1'b0; q_vs = 1'b0;
    do_reset();

    // Frame A: manual, black_r=64. R 100/64/50 -> 36/0/0.
    vs();
    line(6, '{100, 7, 64, 9, 50, 11}, '{36, 7, 0, 9, 0, 11});
    line(4, '{5, 20, 6, 30, 0, 0},   '{5, 20, 6, 30, 0, 0});
    chk("A_est_valid", 64'(est_valid), 1);
    chk_est("A", 82, 8, 6, 25);
    drive(1'b0, 1'b0, '0, '0);
    chk("A_est_valid_low", 64'(est_valid), 0);

    // Frame B: auto, levels 82/8/6/25; mode and black_r change mid-frame.
    auto_en = 1'b1;
    vs();
    line(6, '{60, 10, 61, 3, 200, 0}, '{0, 2, 0, 0, 118, 0});
    auto_en = 1'b0; black_r = 12'd10;
    line(4, '{4, 9, 4, 9, 0, 0}, '{0, 0, 0, 0, 0, 0});
    chk("B_est_valid", 64'(est_valid), 1);
    chk_est("B", 61, 7, 4, 9);
    line(2, '{100, 50, 0, 0, 0, 0}, '{18, 42, 0, 0, 0, 0});
    chk("B_pulses", 64'(pulses), 2);

    // Frame C: auto, est_r=61 -> R 100 gives 39. Single line: no update.
    auto_en = 1'b1;
    vs();
    line(4, '{100, 20, 64, 30, 0, 0}, '{39, 13, 3, 23, 0, 0});
    bypass = 1'b1; auto_en = 1'b0; black_r = 12'd64;
    vs();
    chk("C_pulses", 64'(pulses), 2);
    chk_est("C", 61, 7, 4, 9);

    // Frame D: bypass passes raw, estimates still refresh.
    line(4, '{100, 5, 30, 7, 0, 0}, '{100, 5, 30, 7, 0, 0});
    line(4, '{1, 2, 3, 4, 0, 0},    '{1, 2, 3, 4, 0, 0});
    chk("D_est_valid", 64'(est_valid), 1);
    chk_est("D", 65, 6, 2, 3);
    bypass = 1'b0;
    line(2, '{100, 70, 0, 0, 0, 0}, '{36, 70, 0, 0, 0, 0});
    chk("D_pulses", 64'(pulses), 3);

    // Frame E: reset mid-line; idle until next frame start.
    vs();
    drive(1'b1, 1'b0, 12'd100, 12'd36);
    drive(1'b1, 1'b0, 12'd5, 12'd5);
    do_reset();
    drive(1'b1, 1'b0, 12'd80, 12'd80);
    drive(1'b1, 1'b0, 12'd3, 12'd3);
    drive(1'b0, 1'b0, '0, '0);
    line(4, '{10, 20, 30, 40, 0, 0}, '{10, 20, 30, 40, 0, 0});
    drive(1'b0, 1'b0, '0, '0);
    chk("E_pulses", 64'(pulses), 3);
    chk_est("E", 0, 0, 0, 0);

    // First frame after reset in auto mode uses level 0.
    auto_en = 1'b1;
    vs();
    line(2, '{100, 5, 0, 0, 0, 0}, '{100, 5, 0, 0, 0, 0});
    drive(1'b0, 1'b0, '0, '0);
    chk("F_pulses", 64'(pulses), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
